// File: rtl/rst_seq_ctrl.sv
// Reset sequencer: filters PLL lock, then releases N_DOM reset domains in index order with programmable spacing.
// Optional lock-loss event counter built when RSTSEQ_LOSS_CNT_EN is defined.
//
// state       | meaning
// ------------+------------------------------------------------------------
// WAIT_LOCK   | all domains held, waiting for lock_i
// FILTER      | counting consecutive lock-high cycles up to LOCK_FILT
// RELEASE     | releasing one domain every STEP_DLY cycles
// RUN         | all domains released, done_o high
// HOLD        | software re-sequence: all domains held for HOLD_CYC cycles
module rst_seq_ctrl #(
    parameter int N_DOM     = 3,
    parameter int LOCK_FILT = 16,
    parameter int STEP_DLY  = 8,
    parameter int HOLD_CYC  = 4
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             lock_i,
    input  logic             sw_req_i,
    input  logic             test_mode_i,
    input  logic             pll_bps_i,
    output logic [N_DOM-1:0] rst_no,
    output logic             done_o,
    output logic             lock_lost_o,
    output logic [7:0]       loss_cnt_o
);

    localparam int CMAX = (LOCK_FILT > STEP_DLY)
                        ? ((LOCK_FILT > HOLD_CYC) ? LOCK_FILT : HOLD_CYC)
                        : ((STEP_DLY > HOLD_CYC) ? STEP_DLY : HOLD_CYC);
    localparam int CW   = $clog2(CMAX + 1);

    typedef enum logic [2:0] {
        S_WAIT_LOCK,
        S_FILTER,
        S_RELEASE,
        S_RUN,
        S_HOLD
    } state_e;

    state_e           state_q;
    logic [CW-1:0]    cnt_q;
    logic [2:0]       idx_q;
    logic [N_DOM-1:0] rst_q;
    logic             done_q;
    logic             lock_lost_q;
    logic             lock_loss;
    logic [N_DOM-1:0] dom_bit;

    // Lock loss only counts once domains have started releasing.
    assign lock_loss = !lock_i && (state_q == S_RELEASE || state_q == S_RUN);
    assign dom_bit   = N_DOM'(1) << idx_q;

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            state_q     <= S_WAIT_LOCK;
            cnt_q       <= '0;
            idx_q       <= '0;
            rst_q       <= '0;
            done_q      <= 1'b0;
            lock_lost_q <= 1'b0;
        end else begin
            case (state_q)
                S_WAIT_LOCK: begin
                    rst_q  <= '0;
                    done_q <= 1'b0;
                    if (lock_i) begin
                        state_q <= S_FILTER;
                        cnt_q   <= CW'(1);
                    end else begin
                        cnt_q <= '0;
                    end
                end
                S_FILTER: begin
                    if (!lock_i) begin
                        state_q <= S_WAIT_LOCK;
                        cnt_q   <= '0;
                    end else if (sw_req_i) begin
                        state_q <= S_HOLD;
                        cnt_q   <= '0;
                    end else if (cnt_q == CW'(LOCK_FILT)) begin
                        state_q <= S_RELEASE;
                        cnt_q   <= '0;
                        idx_q   <= '0;
                    end else begin
                        cnt_q <= cnt_q + 1'b1;
                    end
                end
                S_RELEASE, S_RUN: begin
                    if (lock_loss) begin
                        state_q     <= S_WAIT_LOCK;
                        rst_q       <= '0;
                        done_q      <= 1'b0;
                        lock_lost_q <= 1'b1;
                        cnt_q       <= '0;
                        idx_q       <= '0;
                    end else if (sw_req_i) begin
                        state_q <= S_HOLD;
                        rst_q   <= '0;
                        done_q  <= 1'b0;
                        cnt_q   <= '0;
                        idx_q   <= '0;
                    end else if (state_q == S_RELEASE) begin
                        if (cnt_q == CW'(STEP_DLY - 1)) begin
                            rst_q <= rst_q | dom_bit;
                            cnt_q <= '0;
                            idx_q <= idx_q + 3'd1;
                            if (idx_q == 3'(N_DOM - 1)) begin
                                state_q <= S_RUN;
                                done_q  <= 1'b1;
                            end
                        end else begin
                            cnt_q <= cnt_q + 1'b1;
                        end
                    end
                end
                S_HOLD: begin
                    if (!lock_i) begin
                        state_q <= S_WAIT_LOCK;
                        cnt_q   <= '0;
                    end else if (cnt_q == CW'(HOLD_CYC - 1)) begin
                        state_q <= S_FILTER;
                        cnt_q   <= CW'(1);
                    end else begin
                        cnt_q <= cnt_q + 1'b1;
                    end
                end
                default: begin
                    state_q <= S_WAIT_LOCK;
                    cnt_q   <= '0;
                    idx_q   <= '0;
                    rst_q   <= '0;
                    done_q  <= 1'b0;
                end
            endcase
        end
    end

    // Bypass follows the raw reset input so test/PLL-bypass builds see a plain reset tree.
    assign rst_no      = (test_mode_i || pll_bps_i) ? {N_DOM{rst_ni}} : rst_q;
    assign done_o      = done_q;
    assign lock_lost_o = lock_lost_q;

`ifdef RSTSEQ_LOSS_CNT_EN
    logic [7:0] loss_cnt_q;
    logic [7:0] loss_cnt_d;

    always_comb begin
        loss_cnt_d = loss_cnt_q;
        if (lock_loss && loss_cnt_q != 8'hFF) begin
            loss_cnt_d = loss_cnt_q + 8'd1;
        end
    end

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            loss_cnt_q <= 8'h00;
        end else begin
            loss_cnt_q <= loss_cnt_d;
        end
    end

    assign loss_cnt_o = loss_cnt_q;
`else
    assign loss_cnt_o = 8'h00;
`endif

endmodule

// File: tb/tb_rst_seq_ctrl.sv
// Self-checking bench for rst_seq_ctrl with default parameters.
module tb_rst_seq_ctrl;

    localparam int N  = 3;
    localparam int LF = 16;
    localparam int SD = 8;
    localparam int HC = 4;
`ifdef RSTSEQ_LOSS_CNT_EN
    localparam logic [7:0] CNT1 = 8'd1;
`else
    localparam logic [7:0] CNT1 = 8'd0;
`endif

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       lock = 1'b0;
    logic       sw_req = 1'b0;
    logic       tm = 1'b0;
    logic       bps = 1'b0;
    logic [2:0] rst_no;
    logic       done;
    logic       lost;
    logic [7:0] loss_cnt;

    int total = 0;
    int bad = 0;

    always #5 clk = ~clk;

    rst_seq_ctrl #(
        .N_DOM(N), .LOCK_FILT(LF), .STEP_DLY(SD), .HOLD_CYC(HC)
    ) dut (
        .clk_i(clk),
        .rst_ni(rst_n),
        .lock_i(lock),
        .sw_req_i(sw_req),
        .test_mode_i(tm),
        .pll_bps_i(bps),
        .rst_no(rst_no),
        .done_o(done),
        .lock_lost_o(lost),
        .loss_cnt_o(loss_cnt)
    );

    typedef struct {
        logic       rst_n;
        logic       tm;
        logic       bps;
        logic [2:0] exp_rst;
        logic       exp_done;
    } vec_t;

    vec_t vecs[6];

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%0h exp=%0h at %0t", name, got, exp, $time);
        end
    endtask

    function automatic logic [2:0] exp_mask(input int t);
        logic [2:0] m;
        m = 3'b000;
        for (int k = 0; k < N; k++) begin
            if (t >= LF + (k + 1) * SD) m[k] = 1'b1;
        end
        return m;
    endfunction

    task automatic do_reset();
        rst_n = 1'b0; lock = 1'b0; sw_req = 1'b0; tm = 1'b0; bps = 1'b0;
        repeat (3) @(negedge clk);
        chk("reset rst_no", 32'(rst_no), 32'd0);
        chk("reset done", 32'(done), 32'd0);
        chk("reset lock_lost", 32'(lost), 32'd0);
        chk("reset loss_cnt", 32'(loss_cnt), 32'd0);
        rst_n = 1'b1;
    endtask

    // t counts edges after the trigger edge; off shifts the release schedule (HOLD prefix).
    task automatic run_release(input string name, input int off, input logic exp_lost);
        for (int t = 0; t <= off + LF + N * SD + 2; t++) begin
            @(negedge clk);
            sw_req = 1'b0;
            chk({name, " rst_no"}, 32'(rst_no), 32'(exp_mask(t - off)));
            chk({name, " done"}, 32'(done), 32'((t - off) >= LF + N * SD));
            chk({name, " lock_lost"}, 32'(lost), 32'(exp_lost));
        end
    endtask

    initial begin
        vecs[0] = '{rst_n: 1'b1, tm: 1'b1, bps: 1'b0, exp_rst: 3'b111, exp_done: 1'b0};
        vecs[1] = '{rst_n: 1'b1, tm: 1'b0, bps: 1'b1, exp_rst: 3'b111, exp_done: 1'b0};
        vecs[2] = '{rst_n: 1'b1, tm: 1'b1, bps: 1'b1, exp_rst: 3'b111, exp_done: 1'b0};
        vecs[3] = '{rst_n: 1'b1, tm: 1'b0, bps: 1'b0, exp_rst: 3'b000, exp_done: 1'b0};
        vecs[4] = '{rst_n: 1'b0, tm: 1'b0, bps: 1'b1, exp_rst: 3'b000, exp_done: 1'b0};
        vecs[5] = '{rst_n: 1'b0, tm: 1'b1, bps: 1'b0, exp_rst: 3'b000, exp_done: 1'b0};

        do_reset();

        // Bypass mux in WAIT_LOCK
        for (int i = 0; i < 6; i++) begin
            rst_n = vecs[i].rst_n; tm = vecs[i].tm; bps = vecs[i].bps;
            @(negedge clk);
            chk($sformatf("vec%0d rst_no", i), 32'(rst_no), 32'(vecs[i].exp_rst));
            chk($sformatf("vec%0d done", i), 32'(done), 32'(vecs[i].exp_done));
        end

        // Short lock pulse must not start sequencing; stable lock then re-runs the full filter
        do_reset();
        lock = 1'b1;
        for (int t = 0; t < 10; t++) begin
            @(negedge clk);
            chk("pulse rst_no", 32'(rst_no), 32'd0);
        end
        lock = 1'b0;
        for (int t = 0; t < 3; t++) begin
            @(negedge clk);
            chk("pulse low rst_no", 32'(rst_no), 32'd0);
            chk("pulse lock_lost", 32'(lost), 32'd0);
        end
        lock = 1'b1;
        run_release("rel_after_pulse", 0, 1'b0);

        // One-cycle lock drop in RUN
        lock = 1'b0;
        @(negedge clk);
        chk("loss rst_no", 32'(rst_no), 32'd0);
        chk("loss done", 32'(done), 32'd0);
        chk("loss lock_lost", 32'(lost), 32'd1);
        chk("loss loss_cnt", 32'(loss_cnt), 32'(CNT1));
        lock = 1'b1;
        run_release("relock", 0, 1'b1);

        // Software re-sequence from RUN
        do_reset();
        lock = 1'b1;
        run_release("rel_fresh", 0, 1'b0);
        sw_req = 1'b1;
        run_release("sw_req", HC, 1'b0);
        chk("sw_req loss_cnt", 32'(loss_cnt), 32'd0);

        // Lock drop during HOLD is not a lock loss
        sw_req = 1'b1;
        @(negedge clk);
        sw_req = 1'b0;
        chk("hold rst_no", 32'(rst_no), 32'd0);
        @(negedge clk);
        lock = 1'b0;
        @(negedge clk);
        chk("hold drop lock_lost", 32'(lost), 32'd0);
        chk("hold drop loss_cnt", 32'(loss_cnt), 32'd0);
        lock = 1'b1;
        run_release("rel_after_hold", 0, 1'b0);

        // sw_req and lock loss in the same RELEASE cycle: lock loss wins
        do_reset();
        lock = 1'b1;
        repeat (20) @(negedge clk);
        sw_req = 1'b1;
        lock = 1'b0;
        @(negedge clk);
        chk("simul rst_no", 32'(rst_no), 32'd0);
        chk("simul lock_lost", 32'(lost), 32'd1);
        chk("simul loss_cnt", 32'(loss_cnt), 32'(CNT1));
        sw_req = 1'b0;
        lock = 1'b1;
        run_release("simul relock", 0, 1'b1);

        // sw_req in WAIT_LOCK is ignored
        do_reset();
        sw_req = 1'b1;
        @(negedge clk);
        sw_req = 1'b0;
        lock = 1'b1;
        run_release("wait_swreq", 0, 1'b0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
